wb_port_scheduler: RTL

WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

---
 rtl/wb_sched_pkg.sv | 21 ++
 rtl/wb_port_scheduler_if.sv | 38 +++
 rtl/wb_sched_watchdog.sv | 39 +++
 rtl/wb_port_scheduler.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_sched_pkg.sv
//==============================================================================
// Module : wb_sched_pkg
// Brief  : Shared state encoding and constants for the write-back port scheduler.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package wb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        SECOND   = 2'd2
    } wb_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         TIMEOUT_W = 8;

endpackage

`default_nettype wire

// File: rtl/wb_port_scheduler_if.sv
//==============================================================================
// Module : wb_port_scheduler_if
// Brief  : W-stage, data-memory response and register-file write port bundle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface wb_port_scheduler_if;
    logic        FlushW;
    logic        wb_valid_W;
    logic [4:0]  A3_W;
    logic [4:0]  A4_W;
    logic [31:0] Res3_W;
    logic [31:0] Res4_W;
    logic        mem_load_W;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        StallW_req;
    logic        busy;
    logic        mem_timeout;

    modport slave (
        input  FlushW, wb_valid_W, A3_W, A4_W, Res3_W, Res4_W,
               mem_load_W, mem_rvalid, mem_rdata,
        output rf_we, rf_wa, rf_wd, StallW_req, busy, mem_timeout
    );

    modport master (
        output FlushW, wb_valid_W, A3_W, A4_W, Res3_W, Res4_W,
               mem_load_W, mem_rvalid, mem_rdata,
        input  rf_we, rf_wa, rf_wd, StallW_req, busy, mem_timeout
    );
endinterface

`default_nettype wire

// File: rtl/wb_sched_watchdog.sv
//==============================================================================
// Module : wb_sched_watchdog
// Brief  : WAIT_MEM cycle counter; flags expiry in the last allowed wait cycle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_sched_watchdog
    import wb_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear_i,
    input  wire logic count_i,
    output logic      expired_o
);

    // Expiry is seen during the final wait cycle so the FSM leaves on that edge.
    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_i) begin
            count_q <= count_q + TIMEOUT_W'(1);
        end
    end

    assign expired_o = count_i && (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/wb_port_scheduler.sv
//==============================================================================
// Module : wb_port_scheduler
// Brief  : Serialises up to two W-stage results onto one register-file write port.
//          Optional memory watchdog: define WB_MEM_TIMEOUT_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_port_scheduler
    import wb_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    wb_port_scheduler_if.slave bus
);

    wb_state_e   state_q;
    logic [4:0]  a3_q;
    logic [4:0]  a4_q;
    logic [31:0] res4_q;
    logic        rf_we_q;
    logic [4:0]  rf_wa_q;
    logic [31:0] rf_wd_q;

    logic w_accept;
    logic w_expired;

    assign w_accept = (state_q == IDLE) && bus.wb_valid_W && !bus.FlushW;

`ifdef WB_MEM_TIMEOUT_EN
    logic mem_timeout_q;

    wb_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (w_accept && bus.mem_load_W),
        .count_i   (state_q == WAIT_MEM),
        .expired_o (w_expired)
    );

    // A response arriving in the expiry cycle wins over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_timeout_q <= 1'b0;
        end else begin
            mem_timeout_q <= w_expired && !bus.mem_rvalid;
        end
    end

    assign bus.mem_timeout = mem_timeout_q;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_expired            = 1'b0;
    assign bus.mem_timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a3_q    <= REG_ZERO;
            a4_q    <= REG_ZERO;
            res4_q  <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= REG_ZERO;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        a3_q   <= bus.A3_W;
                        a4_q   <= bus.A4_W;
                        res4_q <= bus.Res4_W;
                        if (bus.mem_load_W) begin
                            state_q <= WAIT_MEM;
                        end else begin
                            if (bus.A3_W != REG_ZERO) begin
                                rf_we_q <= 1'b1;
                                rf_wa_q <= bus.A3_W;
                                rf_wd_q <= bus.Res3_W;
                            end else if (bus.A4_W != REG_ZERO) begin
                                rf_we_q <= 1'b1;
                                rf_wa_q <= bus.A4_W;
                                rf_wd_q <= bus.Res4_W;
                            end
                            if ((bus.A3_W != REG_ZERO) && (bus.A4_W != REG_ZERO)) begin
                                state_q <= SECOND;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid || w_expired) begin
                        if (bus.mem_rvalid && (a3_q != REG_ZERO)) begin
                            rf_we_q <= 1'b1;
                            rf_wa_q <= a3_q;
                            rf_wd_q <= bus.mem_rdata;
                        end
                        state_q <= (a4_q != REG_ZERO) ? SECOND : IDLE;
                    end
                end
                SECOND: begin
                    // Only entered with a nonzero latched A4.
                    rf_we_q <= 1'b1;
                    rf_wa_q <= a4_q;
                    rf_wd_q <= res4_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.StallW_req = bus.wb_valid_W && (state_q != IDLE);

endmodule

`default_nettype wire
